// File: rtl/arith_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit_pipe
// Description : Two-stage valid/ready adder D = A + Y + cin with Y in
//               {B, ~B, 0, all-ones}, status flags and an accumulator that
//               can feed operand A and capture results. Define ARITH_SAT_EN
//               to clamp signed overflow to the nearest signed extreme.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_unit_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_s,
  input  logic             in_cin,
  input  logic             in_use_acc,
  input  logic             in_acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc_q
);

  localparam int c_msb = WIDTH - 1;

  // Stage 1: captured operands
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_y;
  logic             r_s1_cin;
  logic             r_s1_acc_wr;

  // Stage 2: registered result and flags
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_d;
  logic             r_s2_cout;
  logic             r_s2_zero;
  logic             r_s2_neg;
  logic             r_s2_ovf;
  logic             r_s2_acc_wr;

  logic [WIDTH-1:0] r_acc;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_s2_load;
  logic             w_interlock;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_c_into_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_d;

  // An acc-sourced operand must wait until every pending accumulator write
  // has left the pipeline, otherwise it would read a stale value.
  assign w_interlock = in_use_acc &&
                       ((r_s1_valid && r_s1_acc_wr) || (r_s2_valid && r_s2_acc_wr));

  assign w_out_fire = r_s2_valid && out_ready;
  assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready   = (!r_s1_valid || w_s2_load) && !w_interlock;
  assign w_in_fire  = in_valid && in_ready;

  assign w_a = in_use_acc ? r_acc : in_a;

  always_comb begin
    w_y = in_b;
    case (in_s)
      2'b00:   w_y = in_b;
      2'b01:   w_y = ~in_b;
      2'b10:   w_y = '0;
      default: w_y = '1;
    endcase
  end

  assign w_sum = {1'b0, r_s1_a} + {1'b0, r_s1_y} + {{WIDTH{1'b0}}, r_s1_cin};

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign w_c_into_msb = r_s1_a[c_msb] ^ r_s1_y[c_msb] ^ w_sum[c_msb];
  assign w_ovf        = w_c_into_msb ^ w_sum[WIDTH];

`ifdef ARITH_SAT_EN
  always_comb begin
    w_d = w_sum[WIDTH-1:0];
    if (w_ovf) begin
      w_d = r_s1_a[c_msb] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_d = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_y      <= '0;
      r_s1_cin    <= 1'b0;
      r_s1_acc_wr <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid  <= 1'b1;
        r_s1_a      <= w_a;
        r_s1_y      <= w_y;
        r_s1_cin    <= in_cin;
        r_s1_acc_wr <= in_acc_wr;
      end else if (w_s2_load) begin
        r_s1_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_d      <= '0;
      r_s2_cout   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_s2_acc_wr <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid  <= 1'b1;
        r_s2_d      <= w_d;
        r_s2_cout   <= w_sum[WIDTH];
        r_s2_zero   <= (w_d == '0);
        r_s2_neg    <= w_d[c_msb];
        r_s2_ovf    <= w_ovf;
        r_s2_acc_wr <= r_s1_acc_wr;
      end else if (w_out_fire) begin
        r_s2_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_out_fire && r_s2_acc_wr) begin
      r_acc <= r_s2_d;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_d     = r_s2_d;
  assign out_cout  = r_s2_cout;
  assign out_zero  = r_s2_zero;
  assign out_neg   = r_s2_neg;
  assign out_ovf   = r_s2_ovf;
  assign acc_q     = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_arith_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit_pipe
// Description : Directed bench for arith_unit_pipe at WIDTH=4 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [3:0] in_a4 = '0, in_b4 = '0, out_d4, acc_q4;
  logic [1:0] in_s4 = '0;
  logic       in_cin4 = 1'b0, use_acc4 = 1'b0, acc_wr4 = 1'b0;
  logic       cout4, zero4, neg4, ovf4;

  // WIDTH=8 instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [7:0] in_a8 = '0, in_b8 = '0, out_d8, acc_q8;
  logic [1:0] in_s8 = '0;
  logic       in_cin8 = 1'b0, use_acc8 = 1'b0, acc_wr8 = 1'b0;
  logic       cout8, zero8, neg8, ovf8;

  arith_unit_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_s(in_s4), .in_cin(in_cin4),
    .in_use_acc(use_acc4), .in_acc_wr(acc_wr4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_d(out_d4), .out_cout(cout4), .out_zero(zero4),
    .out_neg(neg4), .out_ovf(ovf4), .acc_q(acc_q4)
  );

  arith_unit_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_s(in_s8), .in_cin(in_cin8),
    .in_use_acc(use_acc8), .in_acc_wr(acc_wr8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_d(out_d8), .out_cout(cout8), .out_zero(zero8),
    .out_neg(neg8), .out_ovf(ovf8), .acc_q(acc_q8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [1:0] s;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       ovf;
  } vec4_t;

  localparam int N4 = 11;
  vec4_t tbl [N4];

  // Expected values are written for wrapping arithmetic; with saturation the
  // overflowing rows clamp toward the sign of A.
  function automatic vec4_t adjust(input vec4_t v);
    vec4_t r;
    r = v;
`ifdef ARITH_SAT_EN
    if (v.ovf) begin
      r.d    = v.a[3] ? 4'b1000 : 4'b0111;
      r.neg  = r.d[3];
      r.zero = (r.d == 4'b0000);
    end
`endif
    return r;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                       input logic cin, input logic use_acc, input logic acc_wr,
                       output int stalls);
    stalls = 0;
    in_a8 = a; in_b8 = b; in_s8 = s; in_cin8 = cin;
    use_acc8 = use_acc; acc_wr8 = acc_wr; in_valid8 = 1'b1;
    #1;
    while (!in_ready8 && stalls < 20) begin
      step();
      #1;
      stalls++;
    end
    if (!in_ready8) chk("send8_timeout", 32'(in_ready8), 32'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; use_acc8 = 1'b0; acc_wr8 = 1'b0;
  endtask

  task automatic get8(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    while (!out_valid8 && n < 10) begin
      step();
      n++;
    end
    chk({name, "_valid"}, 32'(out_valid8), 32'd1);
    chk({name, "_d"}, 32'(out_d8), 32'(exp));
    step();
  endtask

  logic [7:0] st_a   [4] = '{8'd10, 8'd100, 8'd200, 8'd255};
  logic [7:0] st_b   [4] = '{8'd20, 8'd50, 8'd0, 8'd0};
  logic [1:0] st_s   [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  logic       st_cin [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] st_d   [4] = '{8'd30, 8'd50, 8'd201, 8'd0};
  logic       st_co  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    vec4_t e;
    int    n_in, n_out, st;
    logic  fire;

    //            s      cin   a      b      d      co  z   n   v
    tbl[0]  = '{2'b00, 1'b0, 4'h5, 4'h3, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{2'b00, 1'b1, 4'h5, 4'h3, 4'h9, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{2'b01, 1'b0, 4'h5, 4'h3, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 1'b1, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 1'b0, 4'h5, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 1'b1, 4'h5, 4'h3, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 4'h5, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 1'b1, 4'h5, 4'h3, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'b00, 1'b0, 4'h7, 4'h1, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_d", 32'(out_d4), 32'd0);
    chk("rst_flags", 32'({cout4, zero4, neg4, ovf4}), 32'd0);
    chk("rst_acc", 32'(acc_q8), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready4), 32'd1);

    // WIDTH=4 table, back to back, result expected 2 cycles after handshake
    for (int c = 0; c < N4 + 2; c++) begin
      if (c < N4) begin
        in_valid4 = 1'b1; in_a4 = tbl[c].a; in_b4 = tbl[c].b;
        in_s4 = tbl[c].s; in_cin4 = tbl[c].cin;
      end else begin
        in_valid4 = 1'b0;
      end
      #1;
      if (c < N4) chk($sformatf("w4_in_ready[%0d]", c), 32'(in_ready4), 32'd1);
      if (c == 1) chk("w4_latency", 32'(out_valid4), 32'd0);
      if (c >= 2) begin
        e = adjust(tbl[c-2]);
        chk($sformatf("w4_valid[%0d]", c-2), 32'(out_valid4), 32'd1);
        chk($sformatf("w4_d[%0d]", c-2), 32'(out_d4), 32'(e.d));
        chk($sformatf("w4_cout[%0d]", c-2), 32'(cout4), 32'(e.cout));
        chk($sformatf("w4_zero[%0d]", c-2), 32'(zero4), 32'(e.zero));
        chk($sformatf("w4_neg[%0d]", c-2), 32'(neg4), 32'(e.neg));
        chk($sformatf("w4_ovf[%0d]", c-2), 32'(ovf4), 32'(e.ovf));
      end
      step();
    end
    chk("w4_drained", 32'(out_valid4), 32'd0);

    // WIDTH=8 back-pressure: out_ready low for 3 cycles once a result shows
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready8 = (c >= 5);
      in_valid8 = (n_in < 4);
      if (n_in < 4) begin
        in_a8 = st_a[n_in]; in_b8 = st_b[n_in];
        in_s8 = st_s[n_in]; in_cin8 = st_cin[n_in];
      end
      #1;
      if (c < 2) chk($sformatf("st_in_ready_open[%0d]", c), 32'(in_ready8), 32'd1);
      if (c >= 2 && c <= 4) begin
        chk($sformatf("st_hold_valid[%0d]", c), 32'(out_valid8), 32'd1);
        chk($sformatf("st_hold_d[%0d]", c), 32'(out_d8), 32'd30);
        chk($sformatf("st_in_ready_closed[%0d]", c), 32'(in_ready8), 32'd0);
      end
      if (out_valid8 && out_ready8) begin
        if (n_out < 4) begin
          chk($sformatf("st_d[%0d]", n_out), 32'(out_d8), 32'(st_d[n_out]));
          chk($sformatf("st_cout[%0d]", n_out), 32'(cout8), 32'(st_co[n_out]));
        end else begin
          chk("st_duplicate", 32'(n_out), 32'd3);
        end
        n_out++;
      end
      fire = in_valid8 && in_ready8;
      step();
      if (fire) n_in++;
    end
    in_valid8 = 1'b0;
    chk("st_count", 32'(n_out), 32'd4);
    chk("st_idle", 32'(out_valid8), 32'd0);

    // Accumulator forwarding with interlock
    out_ready8 = 1'b1;
    send8(8'd5, 8'd0, 2'b10, 1'b1, 1'b0, 1'b1, st);
    chk("acc_t1_stall", 32'(st), 32'd0);
    send8(8'd0, 8'd0, 2'b10, 1'b1, 1'b1, 1'b1, st);
    chk("acc_t2_stall", 32'(st), 32'd2);
    chk("acc_after_t1", 32'(acc_q8), 32'd6);
    get8("acc_t2", 8'd7);
    chk("acc_after_t2", 32'(acc_q8), 32'd7);
    send8(8'd0, 8'd0, 2'b10, 1'b1, 1'b1, 1'b0, st);
    chk("acc_t3_stall", 32'(st), 32'd0);
    get8("acc_t3", 8'd8);
    chk("acc_after_t3", 32'(acc_q8), 32'd7);

    // Asynchronous reset with two transactions in flight
    in_valid8 = 1'b1; in_a8 = 8'd9; in_b8 = 8'd1; in_s8 = 2'b00; in_cin8 = 1'b0;
    acc_wr8 = 1'b1;
    step();
    in_a8 = 8'd3; in_b8 = 8'd3; acc_wr8 = 1'b0;
    out_ready8 = 1'b0;
    step();
    in_valid8 = 1'b0;
    chk("ar_inflight", 32'(out_valid8), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid8), 32'd0);
    chk("ar_out_d", 32'(out_d8), 32'd0);
    chk("ar_acc", 32'(acc_q8), 32'd0);
    step();
    rst = 1'b0;
    out_ready8 = 1'b1;
    #1;
    chk("ar_in_ready", 32'(in_ready8), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("ar_no_stale[%0d]", c), 32'(out_valid8), 32'd0);
    end
    chk("ar_acc_kept", 32'(acc_q8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
